// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad decode path.
package keypad_pkg;

  localparam int NUM_KEYS = 20;
  localparam int CODE_W   = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HELD     = 2'd1,
    ERR_WAIT = 2'd2
  } key_state_t;

  function automatic logic is_valid_code(input logic [CODE_W-1:0] code);
    return code < CODE_W'(NUM_KEYS);
  endfunction

  function automatic logic [NUM_KEYS-1:0] code_to_onehot(input logic [CODE_W-1:0] code);
    logic [NUM_KEYS-1:0] one;
    one = {{(NUM_KEYS-1){1'b0}}, 1'b1};
    return one << code;
  endfunction

endpackage

// File: rtl/key_repeat_timer.sv
// Hold/auto-repeat timer: first pulse after HOLD_CYCLES of run, then every
// REPEAT_CYCLES. clear has priority and returns to the first-hold phase.
module key_repeat_timer #(
  parameter int HOLD_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic repeat_p
);

  logic [CNT_W-1:0] cnt;
  logic             phase_rep;
  logic [CNT_W-1:0] limit;

  assign limit = phase_rep ? CNT_W'(REPEAT_CYCLES - 1) : CNT_W'(HOLD_CYCLES - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      phase_rep <= 1'b0;
      repeat_p  <= 1'b0;
    end else if (clear) begin
      cnt       <= '0;
      phase_rep <= 1'b0;
      repeat_p  <= 1'b0;
    end else if (run) begin
      if (cnt == limit) begin
        cnt       <= '0;
        phase_rep <= 1'b1;
        repeat_p  <= 1'b1;
      end else begin
        cnt      <= cnt + CNT_W'(1);
        repeat_p <= 1'b0;
      end
    end else begin
      repeat_p <= 1'b0;
    end
  end

endmodule

// File: rtl/keycode_decoder.sv
// Keypad code decoder: registered one-hot held key plus press/release/err
// pulses. Auto-repeat is built only when KEY_REPEAT_EN is defined.
//
// state    | meaning
// IDLE     | no key held, waiting for a valid strobe
// HELD     | valid key latched, repeat timer running
// ERR_WAIT | invalid code seen, waiting for full release
module keycode_decoder
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CODE_W-1:0]   code,
  input  logic                strobe,
  output logic [NUM_KEYS-1:0] key_onehot,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid,
  output logic                press,
  output logic                release_p,
  output logic                repeat_p,
  output logic                err
);

  key_state_t          state, state_n;
  logic [NUM_KEYS-1:0] onehot_n;
  logic [CODE_W-1:0]   code_n;
  logic                valid_n, press_n, release_n, err_n;
  logic                code_ok;

  assign code_ok = is_valid_code(code);

  always_comb begin
    state_n   = state;
    onehot_n  = key_onehot;
    code_n    = key_code;
    valid_n   = key_valid;
    press_n   = 1'b0;
    release_n = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE: begin
        if (strobe && code_ok) begin
          state_n  = HELD;
          onehot_n = code_to_onehot(code);
          code_n   = code;
          valid_n  = 1'b1;
          press_n  = 1'b1;
        end else if (strobe) begin
          state_n = ERR_WAIT;
          err_n   = 1'b1;
        end
      end
      HELD: begin
        if (!strobe || !code_ok) begin
          state_n   = strobe ? ERR_WAIT : IDLE;
          onehot_n  = '0;
          code_n    = '0;
          valid_n   = 1'b0;
          release_n = 1'b1;
          err_n     = strobe;
        end else if (code != key_code) begin
          // rollover: drop the old key and accept the new one in one cycle
          onehot_n  = code_to_onehot(code);
          code_n    = code;
          release_n = 1'b1;
          press_n   = 1'b1;
        end
      end
      ERR_WAIT: begin
        if (!strobe) state_n = IDLE;
      end
      default: begin
        state_n  = IDLE;
        onehot_n = '0;
        code_n   = '0;
        valid_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      key_onehot <= '0;
      key_code   <= '0;
      key_valid  <= 1'b0;
      press      <= 1'b0;
      release_p  <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      key_onehot <= onehot_n;
      key_code   <= code_n;
      key_valid  <= valid_n;
      press      <= press_n;
      release_p  <= release_n;
      err        <= err_n;
    end
  end

`ifdef KEY_REPEAT_EN
  logic run;

  // any press, release or error this cycle clears the timer, so it never ties with them
  assign run = (state == HELD) && strobe && code_ok && (code == key_code);

  key_repeat_timer #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .clear   (!run),
    .repeat_p(repeat_p)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^{HOLD_CYCLES, REPEAT_CYCLES, CNT_W};
  assign repeat_p   = 1'b0;
`endif

endmodule

// File: tb/tb_keycode_decoder.sv
// Self-checking bench for keycode_decoder: cycle model plus directed literal checks.
module tb_keycode_decoder;

  localparam int HOLD   = 8;
  localparam int REPEAT = 4;
`ifdef KEY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  code = '0;
  logic        strobe = 1'b0;
  logic [19:0] key_onehot;
  logic [4:0]  key_code;
  logic        key_valid, press, release_p, repeat_p, err;

  int checks = 0;
  int errors = 0;

  keycode_decoder #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REPEAT), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .code      (code),
    .strobe    (strobe),
    .key_onehot(key_onehot),
    .key_code  (key_code),
    .key_valid (key_valid),
    .press     (press),
    .release_p (release_p),
    .repeat_p  (repeat_p),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: which key is held, whether an error lockout is active,
  // and how many cycles the current key has been held since its press.
  int held = -1;
  bit lock = 1'b0;
  int n    = 0;
  bit e_press, e_rel, e_err, e_rep;

  always @(posedge clk) begin
    e_press = 0; e_rel = 0; e_err = 0; e_rep = 0;
    if (!rst) begin
      held = -1; lock = 0; n = 0;
    end else if (lock) begin
      if (!strobe) lock = 0;
    end else if (!strobe) begin
      if (held >= 0) e_rel = 1;
      held = -1;
    end else if (code >= 20) begin
      if (held >= 0) e_rel = 1;
      held = -1; lock = 1; e_err = 1;
    end else if (held < 0) begin
      held = code; e_press = 1; n = 0;
    end else if (held != int'(code)) begin
      held = code; e_press = 1; e_rel = 1; n = 0;
    end else begin
      n++;
      e_rep = REP_EN && n >= HOLD && ((n - HOLD) % REPEAT) == 0;
    end
    #2;
    chk("m_onehot", 32'(key_onehot), (held >= 0) ? (32'd1 << held) : 32'd0);
    chk("m_code",   32'(key_code),   (held >= 0) ? 32'(held) : 32'd0);
    chk("m_valid",  32'(key_valid),  32'(held >= 0));
    chk("m_press",  32'(press),      32'(e_press));
    chk("m_rel",    32'(release_p),  32'(e_rel));
    chk("m_err",    32'(err),        32'(e_err));
    chk("m_rep",    32'(repeat_p),   32'(e_rep));
  end

  task automatic drive(input logic s, input logic [4:0] c);
    @(negedge clk);
    strobe = s;
    code   = c;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #3;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_onehot", 32'(key_onehot), 32'd0);
    chk("rst_press",  32'(press),      32'd0);
    @(negedge clk);
    rst = 1'b1;

    // reset in the middle of a hold
    drive(1'b1, 5'd7);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_onehot", 32'(key_onehot), 32'd0);
    chk("mid_rst_valid",  32'(key_valid),  32'd0);
    chk("mid_rst_code",   32'(key_code),   32'd0);
    @(negedge clk);
    rst = 1'b1;
    after_edge();
    chk("post_rst_press",  32'(press),      32'd1);
    chk("post_rst_onehot", 32'(key_onehot), 32'h00080);
    drive(1'b0, 5'd0);
    drive(1'b0, 5'd0);

    // simple press / release of the highest key
    drive(1'b1, 5'd19);
    after_edge();
    chk("k19_press",  32'(press),      32'd1);
    chk("k19_onehot", 32'(key_onehot), 32'h80000);
    chk("k19_code",   32'(key_code),   32'd19);
    drive(1'b0, 5'd19);
    after_edge();
    chk("k19_rel",    32'(release_p),  32'd1);
    chk("k19_clear",  32'(key_onehot), 32'd0);
    drive(1'b0, 5'd0);

    // rollover 3 -> 12
    drive(1'b1, 5'd3);
    repeat (3) drive(1'b1, 5'd3);
    drive(1'b1, 5'd12);
    after_edge();
    chk("roll_press",  32'(press),      32'd1);
    chk("roll_rel",    32'(release_p),  32'd1);
    chk("roll_onehot", 32'(key_onehot), 32'h01000);
    chk("roll_rep",    32'(repeat_p),   32'd0);
    drive(1'b0, 5'd0);
    drive(1'b0, 5'd0);

    // invalid code, lockout until full release
    drive(1'b1, 5'd20);
    after_edge();
    chk("inv_err",   32'(err),   32'd1);
    chk("inv_press", 32'(press), 32'd0);
    drive(1'b1, 5'd5);
    after_edge();
    chk("lock_press", 32'(press), 32'd0);
    chk("lock_err",   32'(err),   32'd0);
    drive(1'b1, 5'd5);
    drive(1'b0, 5'd5);
    drive(1'b1, 5'd5);
    after_edge();
    chk("unlock_press",  32'(press),      32'd1);
    chk("unlock_onehot", 32'(key_onehot), 32'h00020);
    drive(1'b1, 5'd31);
    after_edge();
    chk("held_inv_rel", 32'(release_p), 32'd1);
    chk("held_inv_err", 32'(err),       32'd1);
    drive(1'b0, 5'd0);
    drive(1'b0, 5'd0);

    // auto-repeat timing on a long hold
    drive(1'b1, 5'd0);
    after_edge();
    chk("rep_press", 32'(press), 32'd1);
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, 5'd0);
      after_edge();
      chk("rep_lit", 32'(repeat_p), 32'(REP_EN && (i == 8 || i == 12 || i == 16)));
    end
    drive(1'b0, 5'd0);
    drive(1'b0, 5'd0);

    // rollover exactly when the first repeat would be due
    drive(1'b1, 5'd2);
    for (int i = 1; i <= 7; i++) drive(1'b1, 5'd2);
    drive(1'b1, 5'd9);
    after_edge();
    chk("tie_press", 32'(press),     32'd1);
    chk("tie_rel",   32'(release_p), 32'd1);
    chk("tie_rep",   32'(repeat_p),  32'd0);
    for (int j = 1; j <= 8; j++) begin
      drive(1'b1, 5'd9);
      after_edge();
      chk("tie_next_rep", 32'(repeat_p), 32'(REP_EN && j == 8));
    end
    drive(1'b0, 5'd0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
